// File: rtl/buffered_parallel_out.sv
// buffered_parallel_out
//   A FIFO of words feeding a parallel-output handshake. A consumer raises the
//   asynchronous level data_req; on each new request one word is popped into
//   data_out, held for SETUP_CYCLES cycles of settling time, then flagged valid
//   with data_rdy until the consumer drops the request.
//
// Ports
//   ref_clk    sole clock, all state on its rising edge
//   rst        asynchronous active-high reset
//   wr_en      push request (ref_clk domain)
//   wr_data    word to push
//   data_req   consumer request level, asynchronous to ref_clk
//   clr_flags  synchronous clear of the sticky overflow/underflow flags
//   data_rdy   data_out is valid for the consumer
//   data_out   parallel word presented to the consumer
//   full       FIFO holds DEPTH words
//   empty      FIFO holds no words
//   level      number of words currently stored
//   overflow   sticky: a push was dropped because the FIFO was full
//   underflow  sticky: a request arrived while the FIFO was empty
module buffered_parallel_out #(
  parameter int DATA_WIDTH   = 24,
  parameter int DEPTH        = 16,
  parameter int SETUP_CYCLES = 2
) (
  input  logic                      ref_clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      data_req,
  input  logic                      clr_flags,
  output logic                      data_rdy,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(SETUP_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DATA,
    SETUP,
    READY
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]         cnt, cnt_nxt;
  logic                  req_m, req_s, req_d;
  logic                  rise;
  logic                  push, pop;
  logic                  overflow_set, underflow_set;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Request synchronizer and edge detect. req_d lags req_s by one cycle so a
  // request held high produces exactly one rise.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes the 2-flop
  // synchronizer a chain rather than a single wire.
  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      req_m <= 1'b0;
      req_s <= 1'b0;
      req_d <= 1'b0;
    end else begin
      req_m <= data_req;
      req_s <= req_m;
      req_d <= req_s;
    end
  end

  assign rise = req_s & ~req_d;

  // ---------------------------------------------------------------------------
  // FIFO storage and bookkeeping. A push while full is dropped even if a pop
  // happens in the same cycle; full is judged on the registered level.
  // ---------------------------------------------------------------------------
  assign full         = (level == (AW + 1)'(DEPTH));
  assign empty        = (level == '0);
  assign push         = wr_en & ~full;
  assign overflow_set = wr_en & full;

  // NOTE: the storage array has no reset; its contents are only observable
  // after a push has written them, and leaving it unreset lets it map to RAM.
  always_ff @(posedge ref_clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW + 1)'(1);
        2'b01:   level <= level - (AW + 1)'(1);
        default: level <= level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output handshake FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every signal driven here gets a default before the case statement;
  // a path that left one unassigned would infer a latch.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    pop           = 1'b0;
    underflow_set = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          if (!empty) begin
            pop       = 1'b1;
            cnt_nxt   = CW'(SETUP_CYCLES);
            state_nxt = SETUP;
          end else begin
            underflow_set = 1'b1;
            state_nxt     = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        // The request already counted as a rise; wait here for data instead
        // of needing a second edge.
        if (!req_s) begin
          state_nxt = IDLE;
        end else if (!empty) begin
          pop       = 1'b1;
          cnt_nxt   = CW'(SETUP_CYCLES);
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        // Abandoning the request here silently discards the popped word.
        cnt_nxt = cnt - CW'(1);
        if (!req_s) begin
          state_nxt = IDLE;
        end else if (cnt == CW'(1)) begin
          state_nxt = READY;
        end
      end
      READY: begin
        if (!req_s) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign data_rdy = (state == READY);

  // data_out only moves on a pop, so it keeps the last word while idle.
  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
    end else if (pop) begin
      data_out <= mem[rd_ptr];
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags: a new error event outranks a clear in the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (overflow_set)   overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;
      if (underflow_set)  underflow <= 1'b1;
      else if (clr_flags) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_buffered_parallel_out.sv
// tb_buffered_parallel_out
//   Directed bench for buffered_parallel_out at default parameters
//   (DATA_WIDTH=24, DEPTH=16, SETUP_CYCLES=2). Inputs change 1 ns after a
//   rising edge and outputs are sampled at the same point.
module tb_buffered_parallel_out;

  localparam int DW    = 24;
  localparam int DEPTH = 16;

  logic          ref_clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          data_req;
  logic          clr_flags;
  logic          data_rdy;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
  logic [4:0]    level;
  logic          overflow;
  logic          underflow;

  int n_vec = 0;
  int n_err = 0;

  buffered_parallel_out dut (
    .ref_clk   (ref_clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .data_req  (data_req),
    .clr_flags (clr_flags),
    .data_rdy  (data_rdy),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 ref_clk = ~ref_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge ref_clk);
      #1;
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    tick(1);
    wr_en   = 1'b0;
  endtask

  // One full request: expects data_rdy exactly 5 edges after data_req rises
  // (2 sync + 1 pop + 2 setup) carrying the word exp.
  task automatic read_word(input logic [DW-1:0] exp, input string name);
    int waited = 0;
    data_req = 1'b1;
    do begin
      tick(1);
      waited++;
    end while (!data_rdy && waited < 20);
    n_vec++;
    if (waited !== 5) begin
      n_err++;
      $display("FAIL %s latency: got %0d edges, expected 5", name, waited);
    end
    n_vec++;
    if (data_out !== exp) begin
      n_err++;
      $display("FAIL %s data: got %h, expected %h", name, data_out, exp);
    end
    data_req = 1'b0;
    tick(4);
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; data_req = 1'b0; clr_flags = 1'b0;
    #1;
    n_vec++; if (data_rdy !== 1'b0)  begin n_err++; $display("FAIL reset data_rdy: got %b, expected 0", data_rdy); end
    n_vec++; if (data_out !== 24'h0) begin n_err++; $display("FAIL reset data_out: got %h, expected 000000", data_out); end
    n_vec++; if (level !== 5'd0)     begin n_err++; $display("FAIL reset level: got %0d, expected 0", level); end
    n_vec++; if (empty !== 1'b1)     begin n_err++; $display("FAIL reset empty: got %b, expected 1", empty); end
    n_vec++; if (full !== 1'b0)      begin n_err++; $display("FAIL reset full: got %b, expected 0", full); end
    n_vec++; if ({overflow, underflow} !== 2'b00) begin n_err++; $display("FAIL reset flags: got %b, expected 00", {overflow, underflow}); end
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_ordered_reads();
    push(24'h000001); push(24'h000002); push(24'h000003);
    n_vec++; if (level !== 5'd3) begin n_err++; $display("FAIL ordered level after pushes: got %0d, expected 3", level); end
    for (int k = 0; k < 3; k++) begin
      logic [DW-1:0] exp;
      exp = DW'(k + 1);
      data_req = 1'b1;
      tick(3); // edge N+2: word popped
      n_vec++; if (data_out !== exp) begin n_err++; $display("FAIL ordered data_out #%0d: got %h, expected %h", k, data_out, exp); end
      n_vec++; if (level !== 5'(2 - k)) begin n_err++; $display("FAIL ordered level #%0d: got %0d, expected %0d", k, level, 2 - k); end
      tick(1); // N+3
      n_vec++; if (data_rdy !== 1'b0) begin n_err++; $display("FAIL ordered early rdy #%0d: got %b, expected 0", k, data_rdy); end
      tick(1); // N+4
      n_vec++; if (data_rdy !== 1'b1) begin n_err++; $display("FAIL ordered rdy at N+4 #%0d: got %b, expected 1", k, data_rdy); end
      tick(15);
      n_vec++; if (data_rdy !== 1'b1 || data_out !== exp) begin n_err++; $display("FAIL ordered hold #%0d: got rdy=%b data=%h, expected rdy=1 data=%h", k, data_rdy, data_out, exp); end
      data_req = 1'b0;
      tick(2); // M+1
      n_vec++; if (data_rdy !== 1'b1) begin n_err++; $display("FAIL ordered release M+1 #%0d: got %b, expected 1", k, data_rdy); end
      tick(1); // M+2
      n_vec++; if (data_rdy !== 1'b0) begin n_err++; $display("FAIL ordered release M+2 #%0d: got %b, expected 0", k, data_rdy); end
      tick(27);
    end
    n_vec++; if (empty !== 1'b1 || level !== 5'd0) begin n_err++; $display("FAIL ordered drained: got empty=%b level=%0d, expected 1/0", empty, level); end
  endtask

  task automatic test_underflow_wait();
    data_req = 1'b1;
    tick(3);
    n_vec++; if (underflow !== 1'b1) begin n_err++; $display("FAIL underflow flag: got %b, expected 1", underflow); end
    tick(6);
    push(24'hABCDEF); // edge K: level becomes 1
    n_vec++; if (level !== 5'd1) begin n_err++; $display("FAIL underflow level after push: got %0d, expected 1", level); end
    tick(1); // K+1: pop
    n_vec++; if (data_out !== 24'hABCDEF || level !== 5'd0) begin n_err++; $display("FAIL underflow pop: got data=%h level=%0d, expected abcdef/0", data_out, level); end
    tick(1); // K+2
    n_vec++; if (data_rdy !== 1'b0) begin n_err++; $display("FAIL underflow early rdy: got %b, expected 0", data_rdy); end
    tick(1); // K+3
    n_vec++; if (data_rdy !== 1'b1) begin n_err++; $display("FAIL underflow rdy at K+3: got %b, expected 1", data_rdy); end
    data_req = 1'b0;
    tick(4);
    clr_flags = 1'b1;
    tick(1);
    clr_flags = 1'b0;
    n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL underflow clear: got %b, expected 0", underflow); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) push(DW'(24'h000100 + i));
    n_vec++; if (full !== 1'b1 || level !== 5'd16 || overflow !== 1'b0) begin n_err++; $display("FAIL overflow fill: got full=%b level=%0d ovf=%b, expected 1/16/0", full, level, overflow); end
    push(24'hDEAD00);
    n_vec++; if (overflow !== 1'b1 || level !== 5'd16) begin n_err++; $display("FAIL overflow extra push: got ovf=%b level=%0d, expected 1/16", overflow, level); end
    // Clear coinciding with another dropped push: the error wins.
    clr_flags = 1'b1; wr_en = 1'b1; wr_data = 24'hDEAD01;
    tick(1);
    wr_en = 1'b0;
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL overflow clear vs error: got %b, expected 1", overflow); end
    tick(1);
    clr_flags = 1'b0;
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL overflow clear: got %b, expected 0", overflow); end
    for (int i = 0; i < DEPTH; i++) read_word(DW'(24'h000100 + i), "overflow drain");
    n_vec++; if (empty !== 1'b1 || underflow !== 1'b0) begin n_err++; $display("FAIL overflow drained: got empty=%b unf=%b, expected 1/0", empty, underflow); end
  endtask

  task automatic test_held_request();
    push(24'h000020); push(24'h000021); push(24'h000022); push(24'h000023);
    data_req = 1'b1;
    tick(100);
    n_vec++; if (level !== 5'd3) begin n_err++; $display("FAIL held level: got %0d, expected 3", level); end
    n_vec++; if (data_rdy !== 1'b1 || data_out !== 24'h000020) begin n_err++; $display("FAIL held output: got rdy=%b data=%h, expected 1/000020", data_rdy, data_out); end
    data_req = 1'b0;
    tick(4);
  endtask

  task automatic test_setup_abort();
    data_req = 1'b1;
    tick(1); // edge N
    data_req = 1'b0;
    tick(2); // N+2: word popped
    n_vec++; if (data_out !== 24'h000021 || level !== 5'd2) begin n_err++; $display("FAIL abort pop: got data=%h level=%0d, expected 000021/2", data_out, level); end
    tick(2); // N+4: would be READY had the abort been ignored
    n_vec++; if (data_rdy !== 1'b0) begin n_err++; $display("FAIL abort rdy: got %b, expected 0", data_rdy); end
    n_vec++; if ({overflow, underflow} !== 2'b00) begin n_err++; $display("FAIL abort flags: got %b, expected 00", {overflow, underflow}); end
    tick(2);
    read_word(24'h000022, "abort next word");
  endtask

  task automatic test_reset_mid();
    push(24'h000030);
    data_req = 1'b1;
    tick(3); // in SETUP with 000023 on data_out
    n_vec++; if (data_out !== 24'h000023 || level !== 5'd1) begin n_err++; $display("FAIL midreset setup: got data=%h level=%0d, expected 000023/1", data_out, level); end
    #1;
    rst = 1'b1;
    #1; // no clock edge in between
    n_vec++; if (data_rdy !== 1'b0 || data_out !== 24'h0) begin n_err++; $display("FAIL midreset outputs: got rdy=%b data=%h, expected 0/000000", data_rdy, data_out); end
    n_vec++; if (level !== 5'd0 || empty !== 1'b1) begin n_err++; $display("FAIL midreset fifo: got level=%0d empty=%b, expected 0/1", level, empty); end
    tick(2);
    rst = 1'b0;
    tick(4); // data_req still high: new rise on an empty FIFO
    n_vec++; if (underflow !== 1'b1) begin n_err++; $display("FAIL midreset new rise: got unf=%b, expected 1", underflow); end
    push(24'h000055);
    tick(1);
    n_vec++; if (data_out !== 24'h000055) begin n_err++; $display("FAIL midreset pop: got %h, expected 000055", data_out); end
    tick(2);
    n_vec++; if (data_rdy !== 1'b1) begin n_err++; $display("FAIL midreset rdy: got %b, expected 1", data_rdy); end
    data_req = 1'b0;
    tick(4);
  endtask

  initial begin
    test_reset();
    test_ordered_reads();
    test_underflow_wait();
    test_overflow();
    test_held_request();
    test_setup_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
